// File: rtl/alarm_timekeeper.sv
// Alarm timekeeper: synchronises the 1 Hz wave into a seconds tick, keeps 24-hour
// time of day and runs the alarm ring/snooze/stop state machine.
module alarm_timekeeper #(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input  logic       clk_100MHz,
  input  logic       rst_n,
  input  logic       clk_1Hz,
  input  logic       time_load,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic       alarm_load,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       sec_tick,
  output logic       alarm_ring,
  output logic [1:0] alarm_state,
  output logic       load_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RINGING = 2'b01,
    SNOOZE  = 2'b10
  } state_e;

  localparam logic [7:0] RING_LIM = 8'(RING_SECS);
  localparam logic [9:0] SNZ_INIT = 10'(SNOOZE_SECS);

  logic       sync1_q, sync2_q, edge_q, tick_q;
  logic [4:0] hh_q, hh_d, inc_hh;
  logic [5:0] mm_q, mm_d, inc_mm;
  logic [5:0] ss_q, ss_d, inc_ss;
  logic [4:0] al_hh_q, al_hh_d;
  logic [5:0] al_mm_q, al_mm_d;
  state_e     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       ring_q, err_q, err_d;
  logic       time_ok, alarm_ok, match;

  // Synchroniser and edge flops reset high, the generator's reset level, so
  // releasing reset with clk_1Hz already high does not look like a rising edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      edge_q  <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= clk_1Hz;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      tick_q  <= sync2_q & ~edge_q;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    inc_ss = ss_q + 6'd1;
    inc_mm = mm_q;
    inc_hh = hh_q;
    if (ss_q == 6'd59) begin
      inc_ss = 6'd0;
      if (mm_q == 6'd59) begin
        inc_mm = 6'd0;
        inc_hh = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
      end else begin
        inc_mm = mm_q + 6'd1;
      end
    end

    time_ok  = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
    alarm_ok = (alarm_hh <= 5'd23) && (alarm_mm <= 6'd59);
    err_d    = (time_load && !time_ok) || (alarm_load && !alarm_ok);

    hh_d = hh_q;
    mm_d = mm_q;
    ss_d = ss_q;
    if (time_load) begin
      if (time_ok) begin
        hh_d = load_hh;
        mm_d = load_mm;
        ss_d = load_ss;
      end
    end else if (tick_q) begin
      hh_d = inc_hh;
      mm_d = inc_mm;
      ss_d = inc_ss;
    end

    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    if (alarm_load && alarm_ok) begin
      al_hh_d = alarm_hh;
      al_mm_d = alarm_mm;
    end

    // Only a tick-driven advance can match; a direct load onto the alarm time cannot.
    match = tick_q && !time_load && alarm_en &&
            (inc_hh == al_hh_q) && (inc_mm == al_mm_q) && (inc_ss == 6'd0);
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (match) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d   = SNOOZE;
            snz_cnt_d = SNZ_INIT;
          end else if (tick_q) begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            if (ring_cnt_q + 8'd1 == RING_LIM) state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick_q) begin
            snz_cnt_d = snz_cnt_q - 10'd1;
            if (snz_cnt_q == 10'd1) begin
              state_d    = RINGING;
              ring_cnt_d = 8'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      al_hh_q    <= '0;
      al_mm_q    <= '0;
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ring_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      al_hh_q    <= al_hh_d;
      al_mm_q    <= al_mm_d;
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ring_q     <= (state_d == RINGING);
      err_q      <= err_d;
    end
  end

  assign hh          = hh_q;
  assign mm          = mm_q;
  assign ss          = ss_q;
  assign sec_tick    = tick_q;
  assign alarm_ring  = ring_q;
  assign alarm_state = state_q;
  assign load_err    = err_q;

endmodule
